sprite_reg_bank: RTL and testbench
==================================

// Module: sprite_reg_bank
// PURPOSE
// - Avalon-MM slave register bank for the VGA sprite engine: NUM_SPRITES x/y coordinate pairs plus control, score and lives.
// - Double-buffered: software writes land in shadow registers. Active registers update only at frame_start, so no tearing.
// - Contains a serial (double-dabble) score-to-BCD converter. Its digits feed the score sprites in the RGB controller.
// PARAMETERS
// - NUM_SPRITES  6   number of x/y coordinate pairs (ninja + objects)
// - COORD_W      11  width of each active coordinate (covers hcount range)
// - SCORE_W      8   score width
// - DIGITS       3   BCD digits out; must satisfy 10**DIGITS > 2**SCORE_W-1
// - LIFE_W       3   lives field width
// - ADDR_W       5   word address width; 2**ADDR_W >= 2*NUM_SPRITES+4
// PORTS
// - clk          in   1              system clock (50 MHz)
// - reset        in   1              synchronous, active-high
// - chipselect   in   1              Avalon select
// - write        in   1              Avalon write strobe
// - read         in   1              Avalon read strobe
// - address      in   ADDR_W         word address
// - writedata    in   16             write data
// - readdata     out  16             read data, fixed latency 1
// - frame_start  in   1              1-cycle pulse at start of vertical blank (clk domain)
// - spr_x        out  NUM_SPRITES*COORD_W  active x, sprite i at [i*COORD_W +: COORD_W]
// - spr_y        out  NUM_SPRITES*COORD_W  active y, same packing
// - screen       out  3              one-hot screen select
// - level        out  3              one-hot level
// - result       out  1              1 = pass
// - nin_life     out  LIFE_W         lives to display
// - bcd_digits   out  DIGITS*4       digit k (10**k) at [4k+:4]
// - bcd_valid    out  1              digits match the active score
// - commit_pulse out  1              1-cycle pulse when shadow is copied to active
// BEHAVIOUR
// - Map (N = NUM_SPRITES): 2i = x[i], 2i+1 = y[i] (i < N).
//   - 2N = CTRL: [1:0] state, [4:2] level, [5] result.
//   - 2N+1 = SCORE. 2N+2 = LIVES.
//   - 2N+3 = STATUS: [0] immediate mode (RW), [1] pending (RO), [15:8] frame counter (RO).
// - Writes: when chipselect&&write, writedata is truncated to the field width and stored in the shadow register.
//   - Unmapped addresses: write ignored, read returns 0.
//   - Any shadow write sets pending. The STATUS write itself does not set pending.
// - Reads: when chipselect&&read, readdata is valid the next cycle.
//   - Returns the shadow value (STATUS returns live bits). Otherwise readdata holds its last value.
// - Commit: on frame_start with pending=1, every active register takes its shadow value in that cycle.
//   - commit_pulse=1 that cycle. pending clears.
//   - frame_start with pending=0: no copy, no pulse.
// - Write coincident with commit: the committed value is the pre-write shadow. The write lands in shadow and pending stays 1.
// - Immediate mode (STATUS[0]=1): each write also updates the active register next cycle.
//   - pending is never set; frame_start is ignored except for the frame counter.
// - Frame counter: increments on every frame_start, wraps 255->0.
// - screen: registered from active state: 00->3'b010, 01->3'b001, 10->3'b100, 11->3'b010.
// - BCD: a commit that changes active score, or an immediate-mode SCORE write, starts the converter.
//   - Busy exactly SCORE_W cycles; bcd_valid=0 while busy.
//   - On completion, bcd_digits update atomically and bcd_valid returns to 1.
//   - A new start while busy aborts and restarts with the new score.
//   - bcd_digits holds its old value until completion.
// - Reset: shadow and active cleared to 0; pending=0; immediate=0; frame counter=0.
//   - screen=3'b010, level=0, result=0, nin_life=0; bcd_digits=0, bcd_valid=1; readdata=0, commit_pulse=0.
//   - Reset mid-conversion abandons the conversion.
// STRUCTURE
// - Package nuny_vga_pkg: register-offset functions of N, STATUS bit indices, screen one-hot constants.
//   - Also a screen_decode function mapping state -> one-hot screen.
// - Sub-module bcd_serial: iterative double-dabble.
//   - Ports: clk, reset, start, bin[SCORE_W], busy, done, digits[DIGITS*4].
//   - One shift per cycle; add-3 applied to each digit >=5 before the shift.
// - Top module: shadow/active register arrays, Avalon decode, commit logic, frame counter.
// TESTING
// - Reset, then read all addresses -> all 0; screen=3'b010; bcd_valid=1, digits=000.
// - Write x[0]=300, y[0]=200, no frame_start -> spr_x[0] still 0, readback 300, STATUS[1]=1.
//   - Pulse frame_start -> spr_x[0]=300 that cycle+1, commit_pulse once, pending=0.
// - Write SCORE=255, commit -> bcd_valid=0 for 8 cycles, then digits 2,5,5.
//   - Repeat with 0 -> 0,0,0; with 99 -> 0,9,9.
// - Write CTRL=0x26 (state=10, level=001, result=1) and commit -> screen=3'b100, level=3'b001, result=1.
//   - Write state=11 and commit -> screen=3'b010.
// - Write x[5] in the same cycle as frame_start -> old shadow committed, pending=1.
//   - Next frame_start -> new value active.
// - Set STATUS[0]=1; write LIVES=3 -> nin_life=3 next cycle with no frame_start.
//   - 256 frame_start pulses -> frame counter wraps to 0.
//   - SCORE=12 then SCORE=200 two cycles later -> restart; final digits 2,0,0.

Source files
------------

// File: rtl/nuny_vga_pkg.sv
// Shared definitions for the VGA sprite register bank: register map offsets,
// STATUS bit positions and the screen one-hot encoding.
package nuny_vga_pkg;

    localparam int STATUS_IMM_BIT  = 0;
    localparam int STATUS_PEND_BIT = 1;
    localparam int STATUS_FCNT_LSB = 8;
    localparam int CTRL_W          = 6;

    localparam logic [2:0] SCREEN_IDLE = 3'b010;
    localparam logic [2:0] SCREEN_GAME = 3'b001;
    localparam logic [2:0] SCREEN_OVER = 3'b100;

    function automatic int ctrl_off(input int n);
        return 2 * n;
    endfunction

    function automatic int score_off(input int n);
        return 2 * n + 1;
    endfunction

    function automatic int lives_off(input int n);
        return 2 * n + 2;
    endfunction

    function automatic int status_off(input int n);
        return 2 * n + 3;
    endfunction

    function automatic logic [2:0] screen_decode(input logic [1:0] st);
        logic [2:0] scr;
        case (st)
            2'b00:   scr = SCREEN_IDLE;
            2'b01:   scr = SCREEN_GAME;
            2'b10:   scr = SCREEN_OVER;
            default: scr = SCREEN_IDLE;
        endcase
        return scr;
    endfunction

endpackage

// File: rtl/sprite_reg_bank_if.sv
// Avalon-MM slave bus bundle between the CPU bridge and the sprite register bank.
interface sprite_reg_bank_if #(parameter int ADDR_W = 5);
    logic              chipselect;
    logic              write;
    logic              read;
    logic [ADDR_W-1:0] address;
    logic [15:0]       writedata;
    logic [15:0]       readdata;

    modport master (output chipselect, write, read, address, writedata, input readdata);
    modport slave  (input chipselect, write, read, address, writedata, output readdata);
endinterface

// File: rtl/sprite_reg_bank_bcd_serial.sv
// Iterative double-dabble: converts bin to DIGITS BCD digits, one shift per clock.
module bcd_serial #(
    parameter int SCORE_W = 8,
    parameter int DIGITS  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [SCORE_W-1:0]    bin,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*4-1:0]   digits
);
    localparam int CNT_W = $clog2(SCORE_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SCORE_W - 1);

    logic [SCORE_W-1:0]  sh_q, sh_d;
    logic [DIGITS*4-1:0] acc_q, acc_d, adj_s, digits_q, digits_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;

    // Add-3 correction on every digit, then shift and sequence the conversion.
    always_comb begin
        adj_s    = acc_q;
        sh_d     = sh_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        digits_d = digits_q;
        for (int k = 0; k < DIGITS; k++) begin
            adj_s[4*k +: 4] = (acc_q[4*k +: 4] >= 4'd5) ? acc_q[4*k +: 4] + 4'd3 : acc_q[4*k +: 4];
        end
        if (start) begin
            sh_d   = bin;
            acc_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            acc_d = {adj_s[DIGITS*4-2:0], sh_q[SCORE_W-1]};
            sh_d  = {sh_q[SCORE_W-2:0], 1'b0};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                busy_d   = 1'b0;
                digits_d = {adj_s[DIGITS*4-2:0], sh_q[SCORE_W-1]};
            end else begin
                busy_d = 1'b1;
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // Conversion state and published digits.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            digits_q <= '0;
        end else begin
            sh_q     <= sh_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            digits_q <= digits_d;
        end
    end

    assign busy   = busy_q;
    assign done   = busy_q && (cnt_q == LAST) && !start;
    assign digits = digits_q;

endmodule

// File: rtl/sprite_reg_bank.sv
// Double-buffered Avalon register bank for the sprite engine: software writes a
// shadow copy, which is committed to the active outputs at frame start.
module sprite_reg_bank
    import nuny_vga_pkg::*;
#(
    parameter int NUM_SPRITES = 6,
    parameter int COORD_W     = 11,
    parameter int SCORE_W     = 8,
    parameter int DIGITS      = 3,
    parameter int LIFE_W      = 3,
    parameter int ADDR_W      = 5
) (
    input  logic                           clk,
    input  logic                           reset,
    sprite_reg_bank_if.slave               bus,
    input  logic                           frame_start,
    output logic [NUM_SPRITES*COORD_W-1:0] spr_x,
    output logic [NUM_SPRITES*COORD_W-1:0] spr_y,
    output logic [2:0]                     screen,
    output logic [2:0]                     level,
    output logic                           result,
    output logic [LIFE_W-1:0]              nin_life,
    output logic [DIGITS*4-1:0]            bcd_digits,
    output logic                           bcd_valid,
    output logic                           commit_pulse
);
    localparam logic [ADDR_W-1:0] CTRL_A   = ADDR_W'(ctrl_off(NUM_SPRITES));
    localparam logic [ADDR_W-1:0] SCORE_A  = ADDR_W'(score_off(NUM_SPRITES));
    localparam logic [ADDR_W-1:0] LIVES_A  = ADDR_W'(lives_off(NUM_SPRITES));
    localparam logic [ADDR_W-1:0] STATUS_A = ADDR_W'(status_off(NUM_SPRITES));

    logic [COORD_W-1:0] x_sh_q [NUM_SPRITES], x_sh_d [NUM_SPRITES];
    logic [COORD_W-1:0] y_sh_q [NUM_SPRITES], y_sh_d [NUM_SPRITES];
    logic [COORD_W-1:0] x_act_q[NUM_SPRITES], x_act_d[NUM_SPRITES];
    logic [COORD_W-1:0] y_act_q[NUM_SPRITES], y_act_d[NUM_SPRITES];
    logic [CTRL_W-1:0]  ctrl_sh_q, ctrl_sh_d, ctrl_act_q, ctrl_act_d;
    logic [SCORE_W-1:0] score_sh_q, score_sh_d, score_act_q, score_act_d;
    logic [LIFE_W-1:0]  lives_sh_q, lives_sh_d, lives_act_q, lives_act_d;
    logic               pending_q, pending_d, imm_q, imm_d;
    logic               commit_pulse_q, commit_pulse_d, bcd_valid_q, bcd_valid_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;
    logic [2:0]         screen_q, screen_d;
    logic [15:0]        readdata_q, readdata_d, rd_spr_s, rd_val_s;

    logic [NUM_SPRITES-1:0] we_x_s, we_y_s;
    logic               wr_s, rd_s, commit_s, any_we_s;
    logic               we_ctrl_s, we_score_s, we_lives_s, we_status_s;
    logic               bcd_start_s, bcd_busy_s, bcd_done_s;
    logic [SCORE_W-1:0] bcd_bin_s;
    logic [15:0]        wd_s;

    // Bus decode, commit/immediate update of shadow and active copies, readback mux.
    always_comb begin
        wd_s        = bus.writedata;
        wr_s        = bus.chipselect && bus.write;
        rd_s        = bus.chipselect && bus.read;
        commit_s    = frame_start && pending_q && !imm_q;
        we_ctrl_s   = wr_s && (bus.address == CTRL_A);
        we_score_s  = wr_s && (bus.address == SCORE_A);
        we_lives_s  = wr_s && (bus.address == LIVES_A);
        we_status_s = wr_s && (bus.address == STATUS_A);
        rd_spr_s    = 16'd0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            we_x_s[i]  = wr_s && (bus.address == ADDR_W'(2 * i));
            we_y_s[i]  = wr_s && (bus.address == ADDR_W'(2 * i + 1));
            x_sh_d[i]  = we_x_s[i] ? wd_s[COORD_W-1:0] : x_sh_q[i];
            y_sh_d[i]  = we_y_s[i] ? wd_s[COORD_W-1:0] : y_sh_q[i];
            x_act_d[i] = (we_x_s[i] && imm_q) ? wd_s[COORD_W-1:0] : (commit_s ? x_sh_q[i] : x_act_q[i]);
            y_act_d[i] = (we_y_s[i] && imm_q) ? wd_s[COORD_W-1:0] : (commit_s ? y_sh_q[i] : y_act_q[i]);
            rd_spr_s   = (bus.address == ADDR_W'(2 * i))     ? 16'(x_sh_q[i]) :
                         (bus.address == ADDR_W'(2 * i + 1)) ? 16'(y_sh_q[i]) : rd_spr_s;
        end
        any_we_s    = (|we_x_s) || (|we_y_s) || we_ctrl_s || we_score_s || we_lives_s;

        ctrl_sh_d   = we_ctrl_s  ? wd_s[CTRL_W-1:0]  : ctrl_sh_q;
        score_sh_d  = we_score_s ? wd_s[SCORE_W-1:0] : score_sh_q;
        lives_sh_d  = we_lives_s ? wd_s[LIFE_W-1:0]  : lives_sh_q;
        ctrl_act_d  = (we_ctrl_s  && imm_q) ? wd_s[CTRL_W-1:0]  : (commit_s ? ctrl_sh_q  : ctrl_act_q);
        score_act_d = (we_score_s && imm_q) ? wd_s[SCORE_W-1:0] : (commit_s ? score_sh_q : score_act_q);
        lives_act_d = (we_lives_s && imm_q) ? wd_s[LIFE_W-1:0]  : (commit_s ? lives_sh_q : lives_act_q);

        // A write racing the commit re-arms pending so its value is picked up next frame.
        pending_d      = (any_we_s && !imm_q) ? 1'b1 : (commit_s ? 1'b0 : pending_q);
        imm_d          = we_status_s ? wd_s[STATUS_IMM_BIT] : imm_q;
        frame_cnt_d    = frame_start ? frame_cnt_q + 8'd1 : frame_cnt_q;
        commit_pulse_d = commit_s;
        screen_d       = screen_decode(ctrl_act_d[1:0]);

        bcd_start_s = (commit_s && (score_sh_q != score_act_q)) || (we_score_s && imm_q);
        bcd_bin_s   = (we_score_s && imm_q) ? wd_s[SCORE_W-1:0] : score_sh_q;
        bcd_valid_d = bcd_start_s ? 1'b0 : (bcd_done_s || !bcd_busy_s);

        case (bus.address)
            CTRL_A:   rd_val_s = 16'(ctrl_sh_q);
            SCORE_A:  rd_val_s = 16'(score_sh_q);
            LIVES_A:  rd_val_s = 16'(lives_sh_q);
            STATUS_A: rd_val_s = {frame_cnt_q, 6'd0, pending_q, imm_q};
            default:  rd_val_s = rd_spr_s;
        endcase
        readdata_d = rd_s ? rd_val_s : readdata_q;
    end

    // Register state; synchronous reset returns everything to the power-up view.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                x_sh_q[i]  <= '0;
                y_sh_q[i]  <= '0;
                x_act_q[i] <= '0;
                y_act_q[i] <= '0;
            end
            ctrl_sh_q      <= '0;
            ctrl_act_q     <= '0;
            score_sh_q     <= '0;
            score_act_q    <= '0;
            lives_sh_q     <= '0;
            lives_act_q    <= '0;
            pending_q      <= 1'b0;
            imm_q          <= 1'b0;
            frame_cnt_q    <= 8'd0;
            commit_pulse_q <= 1'b0;
            screen_q       <= SCREEN_IDLE;
            readdata_q     <= 16'd0;
            bcd_valid_q    <= 1'b1;
        end else begin
            x_sh_q         <= x_sh_d;
            y_sh_q         <= y_sh_d;
            x_act_q        <= x_act_d;
            y_act_q        <= y_act_d;
            ctrl_sh_q      <= ctrl_sh_d;
            ctrl_act_q     <= ctrl_act_d;
            score_sh_q     <= score_sh_d;
            score_act_q    <= score_act_d;
            lives_sh_q     <= lives_sh_d;
            lives_act_q    <= lives_act_d;
            pending_q      <= pending_d;
            imm_q          <= imm_d;
            frame_cnt_q    <= frame_cnt_d;
            commit_pulse_q <= commit_pulse_d;
            screen_q       <= screen_d;
            readdata_q     <= readdata_d;
            bcd_valid_q    <= bcd_valid_d;
        end
    end

    bcd_serial #(.SCORE_W(SCORE_W), .DIGITS(DIGITS)) u_bcd (
        .clk    (clk),
        .reset  (reset),
        .start  (bcd_start_s),
        .bin    (bcd_bin_s),
        .busy   (bcd_busy_s),
        .done   (bcd_done_s),
        .digits (bcd_digits)
    );

    // Flatten the active coordinate arrays onto the packed sprite buses.
    always_comb begin
        spr_x = '0;
        spr_y = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            spr_x[i*COORD_W +: COORD_W] = x_act_q[i];
            spr_y[i*COORD_W +: COORD_W] = y_act_q[i];
        end
    end

    assign bus.readdata = readdata_q;
    assign screen       = screen_q;
    assign level        = ctrl_act_q[4:2];
    assign result       = ctrl_act_q[5];
    assign nin_life     = lives_act_q;
    assign bcd_valid    = bcd_valid_q;
    assign commit_pulse = commit_pulse_q;

endmodule

// File: tb/tb_sprite_reg_bank.sv
// Randomised scoreboard bench for sprite_reg_bank against an address-indexed register model.
module tb_sprite_reg_bank;
    localparam int N  = 6;
    localparam int CW = 11;
    localparam int SW = 8;
    localparam int DG = 3;
    localparam int LW = 3;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic reset, frame_start;
    logic [N*CW-1:0] spr_x, spr_y;
    logic [2:0]      screen, level;
    logic            result, bcd_valid, commit_pulse;
    logic [LW-1:0]   nin_life;
    logic [DG*4-1:0] bcd_digits;

    sprite_reg_bank_if #(.ADDR_W(AW)) bus ();

    sprite_reg_bank #(.NUM_SPRITES(N), .COORD_W(CW), .SCORE_W(SW), .DIGITS(DG),
                      .LIFE_W(LW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .bus(bus), .frame_start(frame_start),
        .spr_x(spr_x), .spr_y(spr_y), .screen(screen), .level(level), .result(result),
        .nin_life(nin_life), .bcd_digits(bcd_digits), .bcd_valid(bcd_valid),
        .commit_pulse(commit_pulse));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int sh[32];
    int act[32];
    int m_pend, m_imm, m_fc, m_rdata, m_pulse, m_left, m_target, m_digits;
    int rd_exp_q[$];
    int bcd_exp_q[$];
    bit rd_chk = 1'b0;
    bit mon_en = 1'b0;
    bit prev_valid = 1'b1;

    function automatic int fmask(input int a);
        if (a < 2 * N) return 32'h7FF;
        if (a == 2 * N)     return 32'h3F;
        if (a == 2 * N + 1) return 32'hFF;
        if (a == 2 * N + 2) return 32'h7;
        return 0;
    endfunction

    function automatic int to_bcd(input int v);
        return (v % 10) | (((v / 10) % 10) << 4) | ((v / 100) << 8);
    endfunction

    function automatic int exp_screen(input int st);
        case (st)
            1:       return 1;
            2:       return 4;
            default: return 2;
        endcase
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model: applies one clock edge of the register-map rules.
    task automatic model_edge(input bit cs, input bit wr, input bit rd, input int a, input int wd, input bit fs);
        bit commit, start;
        int sv;
        if (reset) begin
            for (int i = 0; i < 32; i++) begin sh[i] = 0; act[i] = 0; end
            m_pend = 0; m_imm = 0; m_fc = 0; m_rdata = 0; m_pulse = 0;
            m_left = 0; m_target = 0; m_digits = 0;
            rd_exp_q.delete(); bcd_exp_q.delete();
            rd_chk = 1'b0; prev_valid = 1'b1;
            return;
        end
        rd_chk = cs && rd;
        if (cs && rd) begin
            if (a == 2 * N + 3) m_rdata = (m_fc << 8) | (m_pend << 1) | m_imm;
            else if (a < 2 * N + 3) m_rdata = sh[a];
            else m_rdata = 0;
            rd_exp_q.push_back(m_rdata);
        end
        commit = fs && (m_pend == 1) && (m_imm == 0);
        m_pulse = commit;
        start = 1'b0;
        sv = 0;
        if (commit) begin
            if (act[2 * N + 1] != sh[2 * N + 1]) begin start = 1'b1; sv = sh[2 * N + 1]; end
            for (int i = 0; i < 2 * N + 3; i++) act[i] = sh[i];
            m_pend = 0;
        end
        if (cs && wr && a == 2 * N + 3) begin
            m_imm = wd & 1;
        end else if (cs && wr && a < 2 * N + 3) begin
            sh[a] = wd & fmask(a);
            if (m_imm == 1) begin
                act[a] = sh[a];
                if (a == 2 * N + 1) begin start = 1'b1; sv = sh[a]; end
            end else begin
                m_pend = 1;
            end
        end
        if (fs) m_fc = (m_fc + 1) % 256;
        if (start) begin
            if (m_left > 0 && bcd_exp_q.size() > 0) void'(bcd_exp_q.pop_back());
            bcd_exp_q.push_back(to_bcd(sv));
            m_left = SW;
            m_target = sv;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_digits = to_bcd(m_target);
        end
    endtask

    task automatic cyc(input bit cs, input bit wr, input bit rd, input int a, input int wd, input bit fs);
        bus.chipselect = cs;
        bus.write      = wr;
        bus.read       = rd;
        bus.address    = a[AW-1:0];
        bus.writedata  = wd[15:0];
        frame_start    = fs;
        @(posedge clk);
        model_edge(cs, wr, rd, a, wd, fs);
        #1;
        mon_en = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic wr_reg(input int a, input int wd);
        cyc(1'b1, 1'b1, 1'b0, a, wd, 1'b0);
    endtask

    task automatic rd_reg(input int a);
        cyc(1'b1, 1'b0, 1'b1, a, 0, 1'b0);
    endtask

    task automatic frame();
        cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    endtask

    // Monitor: compares DUT outputs with the model and drains the scoreboards.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < N; i++) begin
                chk($sformatf("spr_x[%0d]", i), int'(spr_x[i*CW +: CW]), act[2 * i]);
                chk($sformatf("spr_y[%0d]", i), int'(spr_y[i*CW +: CW]), act[2 * i + 1]);
            end
            chk("screen", int'(screen), exp_screen(act[2 * N] & 3));
            chk("level", int'(level), (act[2 * N] >> 2) & 7);
            chk("result", int'(result), (act[2 * N] >> 5) & 1);
            chk("nin_life", int'(nin_life), act[2 * N + 2]);
            chk("commit_pulse", int'(commit_pulse), m_pulse);
            chk("bcd_valid", int'(bcd_valid), (m_left == 0) ? 1 : 0);
            chk("bcd_digits", int'(bcd_digits), m_digits);
            chk("readdata_hold", int'(bus.readdata), m_rdata);
            if (rd_chk) begin
                if (rd_exp_q.size() == 0) chk("rd_queue_underflow", 1, 0);
                else chk("readdata", int'(bus.readdata), rd_exp_q.pop_front());
            end
            if (!prev_valid && bcd_valid) begin
                if (bcd_exp_q.size() == 0) chk("bcd_queue_underflow", 1, 0);
                else chk("bcd_result", int'(bcd_digits), bcd_exp_q.pop_front());
            end
            prev_valid = bcd_valid;
        end
    end

    initial begin
        reset = 1'b1;
        bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
        bus.address = '0; bus.writedata = '0; frame_start = 1'b0;
        idle(3);
        reset = 1'b0;

        for (int a = 0; a < 32; a++) rd_reg(a);

        wr_reg(0, 300); wr_reg(1, 200); rd_reg(0); rd_reg(15); idle(2);
        frame(); rd_reg(15); idle(2);

        wr_reg(13, 255); frame(); idle(10);
        wr_reg(13, 0);   frame(); idle(10);
        wr_reg(13, 99);  frame(); idle(10);

        wr_reg(12, 32'h26); frame(); idle(2);
        wr_reg(12, 32'h27); frame(); idle(2);

        wr_reg(10, 55); cyc(1'b1, 1'b1, 1'b0, 10, 77, 1'b1); rd_reg(15); idle(1);
        frame(); rd_reg(15); idle(1);

        wr_reg(15, 1); wr_reg(14, 3); idle(2);
        for (int i = 0; i < 256; i++) frame();
        rd_reg(15);
        wr_reg(13, 12); idle(1); wr_reg(13, 200); idle(12);

        wr_reg(13, 150); idle(3);
        reset = 1'b1; idle(2); reset = 1'b0; idle(10);

        for (int n = 0; n < 3000; n++) begin
            int op, a, wd;
            bit fs;
            op = $urandom_range(0, 99);
            a  = $urandom_range(0, 31);
            wd = $urandom_range(0, 65535);
            fs = ($urandom_range(0, 9) == 0);
            if (op < 3) cyc(1'b1, 1'b1, 1'b0, 15, ($urandom_range(0, 3) == 0) ? 1 : 0, fs);
            else if (op < 45) cyc(1'b1, 1'b1, 1'b0, (a == 15) ? 13 : a, wd, fs);
            else if (op < 65) cyc(1'b1, 1'b0, 1'b1, a, 0, fs);
            else cyc(1'b0, 1'b0, 1'b0, 0, 0, fs);
        end
        wr_reg(15, 0); idle(2); frame(); idle(12);

        chk("rd_queue_empty", rd_exp_q.size(), 0);
        chk("bcd_queue_empty", bcd_exp_q.size(), 0);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
